// File: rtl/input_debounce.sv
// input_debounce: two-flop synchronizer plus per-channel stability-counter debouncer.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   raw_in     raw asynchronous level inputs, one per channel
//   en         debounce enable; low freezes counters and outputs
//   clean_out  debounced registered level per channel
//   rise       one-cycle pulse when clean_out[i] goes 0->1
//   fall       one-cycle pulse when clean_out[i] goes 1->0
module input_debounce #(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             en,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  if (STABLE_CYCLES < 1 || longint'(STABLE_CYCLES) > (64'd1 << CNT_W) - 64'd1) begin : g_bad_param
    $error("input_debounce: STABLE_CYCLES must be in 1..2**CNT_W-1");
  end
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] clean_q, clean_d, rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (en) begin
        if (sync2_q[i] == clean_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == LAST) begin
          cnt_d[i]   = '0;
          clean_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      cnt_q   <= '{default: '0};
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end
  assign clean_out = clean_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce: table vectors, directed corner sequences and random stimulus against a window-based model.
`timescale 1ns/1ps
module tb_input_debounce;
  localparam int W  = 2;
  localparam int ST = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] raw_in = '0;
  logic en = 1'b1;
  logic [W-1:0] clean_out, rise, fall;
  input_debounce #(.WIDTH(W), .STABLE_CYCLES(ST), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in), .en(en),
    .clean_out(clean_out), .rise(rise), .fall(fall)
  );
  always #500 clk = ~clk;
  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] rh [$];
  bit win [W][$];
  logic [W-1:0] m_clean, m_rise, m_fall;
  typedef struct {
    logic [W-1:0] raw;
    logic         en;
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } vec_t;
  vec_t tbl [14];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    rh = '{2'b00, 2'b00};
    for (int i = 0; i < W; i++) win[i].delete();
    m_clean = '0;
    m_rise  = '0;
    m_fall  = '0;
  endtask
  // Raw samples reach the debouncer two edges late; a new level is accepted once the
  // last ST enabled samples since the previous acceptance all disagree with the output.
  task automatic model_edge();
    logic [W-1:0] s;
    bit ok;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s = rh.pop_front();
    rh.push_back(raw_in);
    m_rise = '0;
    m_fall = '0;
    if (!en) return;
    for (int i = 0; i < W; i++) begin
      win[i].push_back(s[i]);
      if (win[i].size() > ST) void'(win[i].pop_front());
      ok = (win[i].size() == ST);
      for (int k = 0; k < win[i].size(); k++) if (win[i][k] == m_clean[i]) ok = 0;
      if (ok) begin
        m_clean[i] = s[i];
        m_rise[i]  = s[i];
        m_fall[i]  = ~s[i];
        win[i].delete();
      end
    end
  endtask
  task automatic step(input logic [W-1:0] r, input logic e);
    raw_in = r;
    en = e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("clean_model", clean_out, m_clean);
    check("rise_model", rise, m_rise);
    check("fall_model", fall, m_fall);
  endtask
  task automatic run(input logic [W-1:0] r, input int n);
    for (int k = 0; k < n; k++) step(r, 1'b1);
  endtask
  task automatic async_reset();
    #200;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_clean", clean_out, 0);
    check("async_rst_rise", rise, 0);
    check("async_rst_fall", fall, 0);
  endtask
  initial begin
    int cnt, idx, cnt2, idx2;
    logic [W-1:0] bseq [5];
    logic         eseq [11];
    tbl[0]  = '{2'b11, 1'b1, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{2'b11, 1'b1, 2'b00, 2'b00, 2'b00};
    tbl[2]  = '{2'b11, 1'b1, 2'b00, 2'b00, 2'b00};
    tbl[3]  = '{2'b11, 1'b1, 2'b00, 2'b00, 2'b00};
    tbl[4]  = '{2'b11, 1'b1, 2'b00, 2'b00, 2'b00};
    tbl[5]  = '{2'b11, 1'b1, 2'b11, 2'b11, 2'b00};
    tbl[6]  = '{2'b11, 1'b1, 2'b11, 2'b00, 2'b00};
    tbl[7]  = '{2'b01, 1'b1, 2'b11, 2'b00, 2'b00};
    tbl[8]  = '{2'b01, 1'b1, 2'b11, 2'b00, 2'b00};
    tbl[9]  = '{2'b01, 1'b1, 2'b11, 2'b00, 2'b00};
    tbl[10] = '{2'b01, 1'b1, 2'b11, 2'b00, 2'b00};
    tbl[11] = '{2'b01, 1'b1, 2'b11, 2'b00, 2'b00};
    tbl[12] = '{2'b01, 1'b1, 2'b01, 2'b00, 2'b10};
    tbl[13] = '{2'b01, 1'b1, 2'b01, 2'b00, 2'b00};
    model_reset();
    raw_in = 2'b11;
    repeat (3) step(2'b11, 1'b1);
    check("reset_clean", clean_out, 0);
    check("reset_rise", rise, 0);
    check("reset_fall", fall, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step(tbl[k].raw, tbl[k].en);
      check($sformatf("tbl%0d_clean", k), clean_out, tbl[k].clean);
      check($sformatf("tbl%0d_rise", k), rise, tbl[k].rise);
      check($sformatf("tbl%0d_fall", k), fall, tbl[k].fall);
    end
    run(2'b00, 8);
    cnt = 0; idx = -1; cnt2 = 0;
    for (int k = 0; k < 8; k++) begin
      step(2'b01, 1'b1);
      if (clean_out == 2'b01 && idx < 0) idx = k;
      if (rise != 0) cnt++;
      if (fall != 0) cnt2++;
    end
    check("step_edge", idx, 5);
    check("step_rises", cnt, 1);
    check("step_falls", cnt2, 0);
    cnt = 0;
    for (int k = 0; k < 11; k++) begin
      step(k < 3 ? 2'b11 : 2'b01, 1'b1);
      if (clean_out[1] || rise != 0 || fall != 0) cnt++;
    end
    check("glitch_rejected", cnt, 0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step(k < 4 ? 2'b11 : 2'b01, 1'b1);
      if (rise[1]) cnt++;
    end
    check("long_high_accepted", cnt, 1);
    run(2'b00, 8);
    bseq = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
    cnt = 0; idx = -1;
    for (int k = 0; k < 11; k++) begin
      step(k < 5 ? bseq[k] : 2'b01, 1'b1);
      if (rise[0]) begin cnt++; idx = k; end
    end
    check("bounce_rises", cnt, 1);
    check("bounce_edge", idx, 9);
    eseq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    cnt = 0; idx = -1;
    for (int k = 0; k < 11; k++) begin
      step(2'b00, eseq[k]);
      if (fall[0]) begin cnt++; idx = k; end
      if (k < 10 && !clean_out[0]) cnt2 = 99;
    end
    check("freeze_falls", cnt, 1);
    check("freeze_edge", idx, 10);
    check("freeze_hold", cnt2, 0);
    run(2'b00, 4);
    run(2'b01, 7);
    run(2'b10, 3);
    async_reset();
    step(2'b10, 1'b1);
    step(2'b10, 1'b1);
    rst_n = 1'b1;
    idx = -1; cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step(2'b11, 1'b1);
      if (rise != 0) begin cnt++; idx = k; check("post_rst_rise", rise, 2'b11); end
    end
    check("post_rst_rise_cnt", cnt, 1);
    check("post_rst_edge", idx, 5);
    run(2'b01, 8);
    idx = -1; idx2 = -1;
    for (int k = 0; k < 8; k++) begin
      step(2'b10, 1'b1);
      if (rise == 2'b10 && fall == 2'b01) idx = k;
      if (rise != 0 || fall != 0) idx2 = k;
    end
    check("cross_edge", idx, 5);
    check("cross_only", idx2, 5);
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
        step(raw_in, 1'b1);
        rst_n = 1'b1;
      end
      step($urandom_range(0, 2) == 0 ? W'($urandom) : raw_in, $urandom_range(0, 9) != 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
